// File: rtl/xseg_ctrl_if.sv
// Bus port for the xseg_ctrl peripheral: select, write enable, address and data.
interface xseg_ctrl_if #(parameter int DATA_W = 32);
  logic              sel;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport master (output sel, we, addr, data_in, input data_out);
  modport slave  (input sel, we, addr, data_in, output data_out);
endinterface

// File: rtl/xseg_ctrl.sv
// Multiplexed 7-segment display scanner with debounced push-button and sticky press flag.
// Define XSEG_DP_EN to enable per-digit decimal points in CTRL[2*DIGITS-1:DIGITS].
module xseg_ctrl #(
  parameter int DATA_W       = 32,
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  xseg_ctrl_if.slave        bus,
  input  logic              btn,
  output logic [7:0]        disp,
  output logic [DIGITS-1:0] disp_sel
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [1:0]          sync;
  logic                stable;
  logic                stable_d;
  logic                sticky;
  logic [CW-1:0]       cnt;
  logic                wr;
  logic                rd;
  logic                rd_btn;
  logic                dp_on;
  logic [3:0]          nib;
  logic [7:0]          disp_next;
  logic                unused_bits;

  assign wr          = bus.sel & bus.we;
  assign rd          = bus.sel & ~bus.we;
  assign rd_btn      = rd & (bus.addr == 2'd2);
  assign unused_bits = &{1'b0, bus.data_in};

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef XSEG_DP_EN
  logic [DIGITS-1:0] dp;
  assign dp_on = dp[idx];
`else
  assign dp_on = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      blank <= '0;
`ifdef XSEG_DP_EN
      dp    <= '0;
`endif
    end else if (wr) begin
      if (bus.addr == 2'd0) value <= bus.data_in[4*DIGITS-1:0];
      if (bus.addr == 2'd1) begin
        blank <= bus.data_in[DIGITS-1:0];
`ifdef XSEG_DP_EN
        dp    <= bus.data_in[2*DIGITS-1:DIGITS];
`endif
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (rd) begin
      case (bus.addr)
        2'd0: bus.data_out[4*DIGITS-1:0] = value;
        2'd1: begin
          bus.data_out[DIGITS-1:0] = blank;
`ifdef XSEG_DP_EN
          bus.data_out[2*DIGITS-1:DIGITS] = dp;
`endif
        end
        2'd2: bus.data_out[1:0] = {sticky, stable};
        default: ;
      endcase
    end
  end

  // Segment pattern is built from the current index so disp and disp_sel update on the same edge.
  always_comb begin
    nib       = value[4*int'(idx) +: 4];
    disp_next = blank[idx] ? 8'hFF : {~dp_on, seg7(nib)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      disp     <= 8'hC0;
      disp_sel <= ~DIGITS'(1);
    end else begin
      if (presc == PW'(REFRESH_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      disp     <= disp_next;
      disp_sel <= ~(DIGITS'(1) << idx);
    end
  end

  // Sticky is set one cycle after the stable rise; a simultaneous read-clear loses to the set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      sticky   <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], btn};
      stable_d <= stable;
      if (sync[1] != stable) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (stable & ~stable_d) sticky <= 1'b1;
      else if (rd_btn)        sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xseg_ctrl.sv
// Directed bench for xseg_ctrl: register table, scan model, debounce and reset sequences.
module tb_xseg_ctrl;
  logic       clk;
  logic       rst;
  logic       btn;
  logic [7:0] disp;
  logic [3:0] disp_sel;

  xseg_ctrl_if #(.DATA_W(32)) bus ();

  xseg_ctrl #(.DATA_W(32), .DIGITS(4), .REFRESH_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .btn(btn), .disp(disp), .disp_sel(disp_sel)
  );

`ifdef XSEG_DP_EN
  localparam logic [7:0] CMASK = 8'hFF;
`else
  localparam logic [7:0] CMASK = 8'h0F;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt[14];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc;
  logic [15:0] ev;
  logic [7:0]  ec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;  4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
      4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;  4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
      4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;  4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
      4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;  4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] exp_disp(input int d);
    logic [7:0] s;
    if (ec[d]) return 8'hFF;
    s = seg_of(ev[4*d +: 4]);
`ifdef XSEG_DP_EN
    if (ec[4+d]) s[7] = 1'b0;
`endif
    return s;
  endfunction

  task automatic shadow(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd0) ev = d[15:0];
    else if (a == 2'd1) ec = d[7:0] & CMASK;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    shadow(a, d);
    tick();
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    chk(name, bus.data_out, exp);
    bus.sel = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    chk(name, bus.data_out, exp);
    tick();
    bus.sel = 1'b0;
  endtask

  task automatic check_scan(input int n);
    int d;
    repeat (n) begin
      tick();
      d = (cyc == 0) ? 0 : int'((cyc - 1) / 4) % 4;
      chk($sformatf("scan_sel d%0d", d), {28'd0, disp_sel}, {28'd0, ~(4'b0001 << d)});
      chk($sformatf("scan_disp d%0d", d), {24'd0, disp}, {24'd0, exp_disp(d)});
    end
  endtask

  initial begin
    vt[0]  = '{1'b0, 2'd0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 2'd1, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vt[4]  = '{1'b1, 2'd0, 32'hFFFF1234, 32'h0};
    vt[5]  = '{1'b0, 2'd0, 32'h0,        32'h1234};
    vt[6]  = '{1'b1, 2'd3, 32'hDEAD,     32'h0};
    vt[7]  = '{1'b0, 2'd3, 32'h0,        32'h0};
    vt[8]  = '{1'b1, 2'd2, 32'h3,        32'h0};
    vt[9]  = '{1'b0, 2'd2, 32'h0,        32'h0};
    vt[10] = '{1'b1, 2'd1, 32'hFF,       32'h0};
    vt[11] = '{1'b0, 2'd1, 32'h0,        {24'd0, CMASK}};
    vt[12] = '{1'b1, 2'd1, 32'h0,        32'h0};
    vt[13] = '{1'b0, 2'd1, 32'h0,        32'h0};

    ev = '0; ec = '0;
    rst = 1'b1; btn = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.data_in = '0;
    tick(); tick();
    chk("rst_disp", {24'd0, disp}, 32'hC0);
    chk("rst_sel", {28'd0, disp_sel}, 32'hE);
    chk("rst_nosel", bus.data_out, 32'h0);
    rst = 1'b0;

    // first index advance after reset
    check_scan(5);

    for (int i = 0; i < 14; i++) begin
      bus.sel = 1'b1; bus.we = vt[i].we; bus.addr = vt[i].addr; bus.data_in = vt[i].wdata;
      #1;
      if (vt[i].we) shadow(vt[i].addr, vt[i].wdata);
      else chk($sformatf("vec[%0d]", i), bus.data_out, vt[i].exp);
      tick();
    end
    bus.sel = 1'b0; bus.we = 1'b0;

    bus.addr = 2'd0;
    #1;
    chk("nosel_read", bus.data_out, 32'h0);
    tick();
    check_scan(18);

    wr(2'd1, 32'h5);
    tick();
    check_scan(20);
    wr(2'd1, 32'h0);
    tick();

    btn = 1'b1;
    repeat (5) tick();
    btn = 1'b0;
    repeat (12) tick();
    rd(2'd2, 32'h0, "btn_glitch");

    btn = 1'b1;
    repeat (12) tick();
    btn = 1'b0;
    rd(2'd2, 32'h3, "btn_press");
    rd(2'd2, 32'h1, "btn_cleared");
    repeat (14) tick();
    rd(2'd2, 32'h0, "btn_released");

    // stable rises at the 10th edge; the read spans the edge where sticky gets set
    btn = 1'b1;
    repeat (10) tick();
    rd(2'd2, 32'h1, "btn_coincide");
    rd(2'd2, 32'h3, "btn_set_wins");
    rd(2'd2, 32'h1, "btn_after_set");

    wr(2'd0, 32'hABCD);
    tick();
    check_scan(6);
    btn = 1'b0;
    repeat (14) tick();
    btn = 1'b1;
    repeat (12) tick();
    peek(2'd2, 32'h3, "pre_rst_btn");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_disp", {24'd0, disp}, 32'hC0);
    chk("arst_sel", {28'd0, disp_sel}, 32'hE);
    peek(2'd0, 32'h0, "arst_value");
    peek(2'd2, 32'h0, "arst_btn");
    btn = 1'b0;
    ev = '0; ec = '0;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    rd(2'd2, 32'h0, "post_rst_btn");
    rd(2'd0, 32'h0, "post_rst_value");

    wr(2'd1, 32'h10);
    rd(2'd1, 32'h10 & {24'd0, CMASK}, "ctrl_dp");
    check_scan(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
